// File: rtl/swervolf_branch_stats.sv
// Branch statistics for the SweRV retire stream: saturating live counters plus
// periodic/on-demand snapshots that hold steady for the seven-segment display.
module swervolf_branch_stats #(
    parameter int CNT_W    = 32,
    parameter int SNAP_DIV = 10000000
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_br_valid,
    input  logic             i_br_taken,
    input  logic             i_br_mispred,
    input  logic             i_clr,
    input  logic             i_freeze,
    input  logic             i_snap_req,
    output logic [CNT_W-1:0] o_branches,
    output logic [CNT_W-1:0] o_taken,
    output logic [CNT_W-1:0] o_mispred,
    output logic [CNT_W-1:0] o_snap_branches,
    output logic [CNT_W-1:0] o_snap_taken,
    output logic             o_snap_valid,
    output logic             o_sat
);

    localparam int               TMR_W    = $clog2(SNAP_DIV);
    localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(SNAP_DIV - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;

    logic [TMR_W-1:0] timer;
    logic [CNT_W-1:0] br_next;
    logic [CNT_W-1:0] tk_next;
    logic [CNT_W-1:0] mp_next;
    logic             count_en;
    logic             sat_hit;
    logic             snap_evt;

    assign count_en = i_br_valid & ~i_freeze;
    assign snap_evt = i_snap_req | (timer == TMR_LAST);

    // Saturating increments: a counter at all-ones holds instead of wrapping.
    always_comb begin
        br_next = o_branches;
        tk_next = o_taken;
        mp_next = o_mispred;
        if (count_en && (o_branches != CNT_MAX)) begin
            br_next = o_branches + CNT_W'(1);
        end
        if (count_en && i_br_taken && (o_taken != CNT_MAX)) begin
            tk_next = o_taken + CNT_W'(1);
        end
        if (count_en && i_br_mispred && (o_mispred != CNT_MAX)) begin
            mp_next = o_mispred + CNT_W'(1);
        end
    end

    assign sat_hit = (br_next == CNT_MAX) | (tk_next == CNT_MAX) | (mp_next == CNT_MAX);

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            o_branches      <= '0;
            o_taken         <= '0;
            o_mispred       <= '0;
            o_snap_branches <= '0;
            o_snap_taken    <= '0;
            o_snap_valid    <= 1'b0;
            o_sat           <= 1'b0;
            timer           <= '0;
        end else begin
            if (i_clr) begin
                o_branches <= '0;
                o_taken    <= '0;
                o_mispred  <= '0;
                o_sat      <= 1'b0;
            end else begin
                o_branches <= br_next;
                o_taken    <= tk_next;
                o_mispred  <= mp_next;
                if (sat_hit) begin
                    o_sat <= 1'b1;
                end
            end

            // Snapshot takes the pre-edge live values, so same-cycle events/clear are excluded.
            if (snap_evt) begin
                o_snap_branches <= o_branches;
                o_snap_taken    <= o_taken;
                timer           <= '0;
            end else begin
                timer <= timer + TMR_W'(1);
            end
            o_snap_valid <= snap_evt;
        end
    end

endmodule

// File: tb/tb_swervolf_branch_stats.sv
// Directed bench for swervolf_branch_stats with CNT_W=8 and SNAP_DIV=8.
module tb_swervolf_branch_stats;

    localparam int CNT_W    = 8;
    localparam int SNAP_DIV = 8;

    logic             clk = 1'b0;
    logic             rst = 1'b0;
    logic             br_valid = 1'b0;
    logic             br_taken = 1'b0;
    logic             br_mispred = 1'b0;
    logic             clr = 1'b0;
    logic             freeze = 1'b0;
    logic             snap_req = 1'b0;
    logic [CNT_W-1:0] branches;
    logic [CNT_W-1:0] taken;
    logic [CNT_W-1:0] mispred;
    logic [CNT_W-1:0] snap_branches;
    logic [CNT_W-1:0] snap_taken;
    logic             snap_valid;
    logic             sat;

    int tests_run    = 0;
    int tests_failed = 0;

    swervolf_branch_stats #(.CNT_W(CNT_W), .SNAP_DIV(SNAP_DIV)) dut (
        .i_clk          (clk),
        .i_rst          (rst),
        .i_br_valid     (br_valid),
        .i_br_taken     (br_taken),
        .i_br_mispred   (br_mispred),
        .i_clr          (clr),
        .i_freeze       (freeze),
        .i_snap_req     (snap_req),
        .o_branches     (branches),
        .o_taken        (taken),
        .o_mispred      (mispred),
        .o_snap_branches(snap_branches),
        .o_snap_taken   (snap_taken),
        .o_snap_valid   (snap_valid),
        .o_sat          (sat)
    );

    always #5 clk = ~clk;

    // One rising edge; inputs are driven and outputs sampled at the falling edge.
    task automatic tick();
        @(negedge clk);
    endtask

    task automatic idle_inputs();
        rst = 1'b0; br_valid = 1'b0; br_taken = 1'b0; br_mispred = 1'b0;
        clr = 1'b0; freeze = 1'b0; snap_req = 1'b0;
    endtask

    task automatic do_reset();
        idle_inputs();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        idle_inputs();
        rst = 1'b1; br_valid = 1'b1; br_taken = 1'b1; br_mispred = 1'b1; snap_req = 1'b1;
        tick();
        tests_run++; if (branches !== 8'd0) begin tests_failed++; $display("FAIL reset_branches: got %0d expected 0", branches); end
        tests_run++; if (taken !== 8'd0) begin tests_failed++; $display("FAIL reset_taken: got %0d expected 0", taken); end
        tests_run++; if (mispred !== 8'd0) begin tests_failed++; $display("FAIL reset_mispred: got %0d expected 0", mispred); end
        tests_run++; if (snap_branches !== 8'd0) begin tests_failed++; $display("FAIL reset_snap_branches: got %0d expected 0", snap_branches); end
        tests_run++; if (snap_taken !== 8'd0) begin tests_failed++; $display("FAIL reset_snap_taken: got %0d expected 0", snap_taken); end
        tests_run++; if (snap_valid !== 1'b0) begin tests_failed++; $display("FAIL reset_snap_valid: got %0b expected 0", snap_valid); end
        tests_run++; if (sat !== 1'b0) begin tests_failed++; $display("FAIL reset_sat: got %0b expected 0", sat); end
        idle_inputs();
    endtask

    task automatic test_count();
        logic [CNT_W-1:0] e_b, e_t, e_m;
        do_reset();
        e_b = 0; e_t = 0; e_m = 0;
        for (int k = 1; k <= 5; k++) begin
            br_valid   = 1'b1;
            br_taken   = (k == 2) || (k == 4);
            br_mispred = (k == 4);
            tick();
            e_b = 8'(k);
            if (k == 2 || k == 4) e_t = e_t + 8'd1;
            if (k == 4) e_m = e_m + 8'd1;
            tests_run++; if (branches !== e_b) begin tests_failed++; $display("FAIL count_branches[%0d]: got %0d expected %0d", k, branches, e_b); end
            tests_run++; if (taken !== e_t) begin tests_failed++; $display("FAIL count_taken[%0d]: got %0d expected %0d", k, taken, e_t); end
            tests_run++; if (mispred !== e_m) begin tests_failed++; $display("FAIL count_mispred[%0d]: got %0d expected %0d", k, mispred, e_m); end
        end
        idle_inputs();
    endtask

    task automatic test_snap_auto();
        logic exp_v;
        do_reset();
        for (int e = 1; e <= 3; e++) begin
            br_valid = 1'b1;
            br_taken = (e == 2);
            tick();
        end
        idle_inputs();
        br_taken = 1'b1; br_mispred = 1'b1;
        tick();
        idle_inputs();
        tests_run++; if (branches !== 8'd3) begin tests_failed++; $display("FAIL unqualified_branches: got %0d expected 3", branches); end
        tests_run++; if (taken !== 8'd1) begin tests_failed++; $display("FAIL unqualified_taken: got %0d expected 1", taken); end
        tests_run++; if (mispred !== 8'd0) begin tests_failed++; $display("FAIL unqualified_mispred: got %0d expected 0", mispred); end
        for (int e = 5; e <= 16; e++) begin
            tick();
            exp_v = (e % SNAP_DIV) == 0;
            tests_run++; if (snap_valid !== exp_v) begin tests_failed++; $display("FAIL auto_snap_valid[edge %0d]: got %0b expected %0b", e, snap_valid, exp_v); end
            if (e == 8) begin
                tests_run++; if (snap_branches !== 8'd3) begin tests_failed++; $display("FAIL auto_snap_branches: got %0d expected 3", snap_branches); end
                tests_run++; if (snap_taken !== 8'd1) begin tests_failed++; $display("FAIL auto_snap_taken: got %0d expected 1", snap_taken); end
            end
        end
    endtask

    task automatic test_saturate();
        do_reset();
        for (int e = 1; e <= 260; e++) begin
            br_valid = 1'b1; br_taken = 1'b1;
            tick();
            if (e == 254) begin
                tests_run++; if (branches !== 8'd254) begin tests_failed++; $display("FAIL sat_pre_branches: got %0d expected 254", branches); end
                tests_run++; if (sat !== 1'b0) begin tests_failed++; $display("FAIL sat_pre_flag: got %0b expected 0", sat); end
            end
            if (e == 255) begin
                tests_run++; if (sat !== 1'b1) begin tests_failed++; $display("FAIL sat_reach_flag: got %0b expected 1", sat); end
            end
        end
        idle_inputs();
        tests_run++; if (branches !== 8'd255) begin tests_failed++; $display("FAIL sat_branches: got %0d expected 255", branches); end
        tests_run++; if (taken !== 8'd255) begin tests_failed++; $display("FAIL sat_taken: got %0d expected 255", taken); end
        tests_run++; if (mispred !== 8'd0) begin tests_failed++; $display("FAIL sat_mispred: got %0d expected 0", mispred); end
        tests_run++; if (sat !== 1'b1) begin tests_failed++; $display("FAIL sat_flag: got %0b expected 1", sat); end
        clr = 1'b1;
        tick();
        idle_inputs();
        tests_run++; if (branches !== 8'd0) begin tests_failed++; $display("FAIL clr_branches: got %0d expected 0", branches); end
        tests_run++; if (taken !== 8'd0) begin tests_failed++; $display("FAIL clr_taken: got %0d expected 0", taken); end
        tests_run++; if (sat !== 1'b0) begin tests_failed++; $display("FAIL clr_sat: got %0b expected 0", sat); end
        tests_run++; if (snap_branches !== 8'd255) begin tests_failed++; $display("FAIL clr_snap_branches: got %0d expected 255", snap_branches); end
        tests_run++; if (snap_taken !== 8'd255) begin tests_failed++; $display("FAIL clr_snap_taken: got %0d expected 255", snap_taken); end
        tests_run++; if (snap_valid !== 1'b0) begin tests_failed++; $display("FAIL clr_snap_valid: got %0b expected 0", snap_valid); end
    endtask

    task automatic test_clr_snap();
        logic exp_v;
        do_reset();
        for (int e = 1; e <= 10; e++) begin
            br_valid = 1'b1;
            tick();
        end
        tests_run++; if (branches !== 8'd10) begin tests_failed++; $display("FAIL pre_clr_branches: got %0d expected 10", branches); end
        clr = 1'b1; br_valid = 1'b1; snap_req = 1'b1;
        tick();
        idle_inputs();
        tests_run++; if (branches !== 8'd0) begin tests_failed++; $display("FAIL clrsnap_branches: got %0d expected 0", branches); end
        tests_run++; if (snap_branches !== 8'd10) begin tests_failed++; $display("FAIL clrsnap_snap_branches: got %0d expected 10", snap_branches); end
        tests_run++; if (snap_valid !== 1'b1) begin tests_failed++; $display("FAIL clrsnap_snap_valid: got %0b expected 1", snap_valid); end
        for (int e = 12; e <= 19; e++) begin
            tick();
            exp_v = (e == 19);
            tests_run++; if (snap_valid !== exp_v) begin tests_failed++; $display("FAIL clrsnap_next_valid[edge %0d]: got %0b expected %0b", e, snap_valid, exp_v); end
        end
        tests_run++; if (snap_branches !== 8'd0) begin tests_failed++; $display("FAIL clrsnap_next_branches: got %0d expected 0", snap_branches); end
    endtask

    task automatic test_freeze();
        logic exp_v;
        do_reset();
        for (int e = 1; e <= 2; e++) begin
            br_valid = 1'b1; br_taken = 1'b1;
            tick();
        end
        freeze = 1'b1;
        for (int e = 3; e <= 22; e++) begin
            tick();
            exp_v = (e % SNAP_DIV) == 0;
            tests_run++; if (branches !== 8'd2) begin tests_failed++; $display("FAIL freeze_branches[edge %0d]: got %0d expected 2", e, branches); end
            tests_run++; if (taken !== 8'd2) begin tests_failed++; $display("FAIL freeze_taken[edge %0d]: got %0d expected 2", e, taken); end
            tests_run++; if (snap_valid !== exp_v) begin tests_failed++; $display("FAIL freeze_snap_valid[edge %0d]: got %0b expected %0b", e, snap_valid, exp_v); end
            if (exp_v) begin
                tests_run++; if (snap_branches !== 8'd2) begin tests_failed++; $display("FAIL freeze_snap_branches[edge %0d]: got %0d expected 2", e, snap_branches); end
            end
        end
        freeze = 1'b0;
        tick();
        tests_run++; if (branches !== 8'd3) begin tests_failed++; $display("FAIL unfreeze_branches: got %0d expected 3", branches); end
        tests_run++; if (taken !== 8'd3) begin tests_failed++; $display("FAIL unfreeze_taken: got %0d expected 3", taken); end
        tick();
        idle_inputs();
        tests_run++; if (branches !== 8'd4) begin tests_failed++; $display("FAIL unfreeze2_branches: got %0d expected 4", branches); end
        tests_run++; if (snap_valid !== 1'b1) begin tests_failed++; $display("FAIL unfreeze_snap_valid: got %0b expected 1", snap_valid); end
        tests_run++; if (snap_branches !== 8'd3) begin tests_failed++; $display("FAIL unfreeze_snap_branches: got %0d expected 3", snap_branches); end
    endtask

    task automatic test_coincide_and_reset();
        logic exp_v;
        do_reset();
        for (int e = 1; e <= 7; e++) tick();
        tests_run++; if (snap_valid !== 1'b0) begin tests_failed++; $display("FAIL coincide_pre_valid: got %0b expected 0", snap_valid); end
        snap_req = 1'b1;
        tick();
        snap_req = 1'b0;
        tests_run++; if (snap_valid !== 1'b1) begin tests_failed++; $display("FAIL coincide_valid: got %0b expected 1", snap_valid); end
        tick();
        tests_run++; if (snap_valid !== 1'b0) begin tests_failed++; $display("FAIL coincide_single_pulse: got %0b expected 0", snap_valid); end
        for (int e = 10; e <= 16; e++) begin
            br_valid = 1'b1;
            tick();
            exp_v = (e == 16);
            tests_run++; if (snap_valid !== exp_v) begin tests_failed++; $display("FAIL coincide_restart[edge %0d]: got %0b expected %0b", e, snap_valid, exp_v); end
        end
        tests_run++; if (snap_branches !== 8'd6) begin tests_failed++; $display("FAIL coincide_snap_branches: got %0d expected 6", snap_branches); end
        tick();
        tests_run++; if (branches !== 8'd8) begin tests_failed++; $display("FAIL midcount_branches: got %0d expected 8", branches); end
        rst = 1'b1; br_valid = 1'b1; br_taken = 1'b1; snap_req = 1'b1;
        tick();
        idle_inputs();
        tests_run++; if (branches !== 8'd0) begin tests_failed++; $display("FAIL midrst_branches: got %0d expected 0", branches); end
        tests_run++; if (taken !== 8'd0) begin tests_failed++; $display("FAIL midrst_taken: got %0d expected 0", taken); end
        tests_run++; if (snap_branches !== 8'd0) begin tests_failed++; $display("FAIL midrst_snap_branches: got %0d expected 0", snap_branches); end
        tests_run++; if (snap_taken !== 8'd0) begin tests_failed++; $display("FAIL midrst_snap_taken: got %0d expected 0", snap_taken); end
        tests_run++; if (snap_valid !== 1'b0) begin tests_failed++; $display("FAIL midrst_snap_valid: got %0b expected 0", snap_valid); end
    endtask

    initial begin
        idle_inputs();
        tick();
        test_reset();
        test_count();
        test_snap_auto();
        test_saturate();
        test_clr_snap();
        test_freeze();
        test_coincide_and_reset();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
